// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// stall/flush priority control and writeback snooping of held operands.
module id_ex_pipe #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [4:0]        id_rd_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              id_mem_read_i,
  input  logic [31:0]       id_read_data1_i,
  input  logic [31:0]       id_read_data2_i,
  input  logic [31:0]       id_imm_i,
  input  logic [31:0]       id_pc_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              ex_stall_i,
  input  logic              flush_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [31:0]       wb_data_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [4:0]        ex_rs1_o,
  output logic [4:0]        ex_rs2_o,
  output logic [4:0]        ex_rd_o,
  output logic              ex_mem_read_o,
  output logic [31:0]       ex_op1_o,
  output logic [31:0]       ex_op2_o,
  output logic [31:0]       ex_imm_o,
  output logic [31:0]       ex_pc_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              r_valid;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic              r_mem_read;
  logic [31:0]       r_op1;
  logic [31:0]       r_op2;
  logic [31:0]       r_imm;
  logic [31:0]       r_pc;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;

  // r0 is an ordinary register here, so select 0 participates in matching.
  assign w_rs1_hit  = id_uses_rs1_i && (id_rs1_i == r_rd);
  assign w_rs2_hit  = id_uses_rs2_i && (id_rs2_i == r_rd);
  assign w_load_use = id_valid_i && r_valid && r_mem_read && (w_rs1_hit || w_rs2_hit);
  assign stall_o    = !flush_i && (ex_stall_i || w_load_use);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid      <= 1'b0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_mem_read   <= 1'b0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_ctrl       <= '0;
      r_bubble_cnt <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (ex_stall_i) begin
      // Held operands must track register-file writes made while Execute waits.
      if (wb_we_i && (wb_rd_i == r_rs1)) r_op1 <= wb_data_i;
      if (wb_we_i && (wb_rd_i == r_rs2)) r_op2 <= wb_data_i;
    end else if (w_load_use) begin
      r_valid <= 1'b0;
      if (r_bubble_cnt != {CNT_W{1'b1}})
        r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_valid    <= id_valid_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
      r_mem_read <= id_mem_read_i;
      r_op1      <= id_read_data1_i;
      r_op2      <= id_read_data2_i;
      r_imm      <= id_imm_i;
      r_pc       <= id_pc_i;
      r_ctrl     <= id_ctrl_i;
    end
  end

  assign ex_valid_o    = r_valid;
  assign ex_rs1_o      = r_rs1;
  assign ex_rs2_o      = r_rs2;
  assign ex_rd_o       = r_rd;
  assign ex_mem_read_o = r_mem_read;
  assign ex_op1_o      = r_op1;
  assign ex_op2_o      = r_op2;
  assign ex_imm_o      = r_imm;
  assign ex_pc_o       = r_pc;
  assign ex_ctrl_o     = r_ctrl;
  assign bubble_cnt_o  = r_bubble_cnt;

endmodule
